// File: rtl/mips_instr_encoder.sv
// Encodes symbolic MIPS operation requests into 32-bit instruction words and
// streams them through a small FIFO to sequential IMEM word addresses.
`timescale 1ns/1ps
module mips_instr_encoder #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  prog_len,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [4:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err_illegal
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FILL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic                err_q, err_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [31:0]         mem_q [DEPTH];

    logic [5:0]          funct_c;
    logic [5:0]          opcode_c;
    logic                is_r_c;
    logic                is_i_c;
    logic                legal_c;
    logic [31:0]         enc_word_c;
    logic                fifo_full_c;
    logic                fifo_empty_c;
    logic                accept_c;
    logic                push_c;
    logic                pop_c;

    // Operation select to funct (R-type) or opcode (I-type) lookup.
    always_comb begin : encode_lookup
        funct_c  = 6'h00;
        opcode_c = 6'h00;
        is_r_c   = 1'b0;
        is_i_c   = 1'b0;
        case (op_sel)
            5'd0:  begin is_r_c = 1'b1; funct_c  = 6'h20; end
            5'd1:  begin is_r_c = 1'b1; funct_c  = 6'h21; end
            5'd2:  begin is_r_c = 1'b1; funct_c  = 6'h22; end
            5'd3:  begin is_r_c = 1'b1; funct_c  = 6'h23; end
            5'd4:  begin is_r_c = 1'b1; funct_c  = 6'h24; end
            5'd5:  begin is_r_c = 1'b1; funct_c  = 6'h25; end
            5'd6:  begin is_r_c = 1'b1; funct_c  = 6'h26; end
            5'd7:  begin is_r_c = 1'b1; funct_c  = 6'h27; end
            5'd8:  begin is_r_c = 1'b1; funct_c  = 6'h2a; end
            5'd9:  begin is_i_c = 1'b1; opcode_c = 6'h04; end
            5'd10: begin is_i_c = 1'b1; opcode_c = 6'h05; end
            5'd11: begin is_i_c = 1'b1; opcode_c = 6'h23; end
            5'd12: begin is_i_c = 1'b1; opcode_c = 6'h2b; end
            5'd13: begin is_i_c = 1'b1; opcode_c = 6'h08; end
            5'd14: begin is_i_c = 1'b1; opcode_c = 6'h09; end
            5'd15: begin is_i_c = 1'b1; opcode_c = 6'h0c; end
            5'd16: begin is_i_c = 1'b1; opcode_c = 6'h0d; end
            5'd17: begin is_i_c = 1'b1; opcode_c = 6'h0e; end
            default: begin end
        endcase
    end

    assign legal_c    = is_r_c | is_i_c;
    assign enc_word_c = is_r_c ? {6'h00, rs, rt, rd, 5'h00, funct_c}
                               : {opcode_c, rs, rt, imm};

    // Handshake decode; op_ready is a pure decode of registered state.
    assign fifo_full_c  = (fill_q == FILL_W'(DEPTH));
    assign fifo_empty_c = (fill_q == '0);
    assign op_ready     = (state_q == ST_RUN) && !fifo_full_c && (rem_q != '0);
    assign accept_c     = op_valid && op_ready;
    assign push_c       = accept_c && legal_c;
    assign pop_c        = !fifo_empty_c && wr_ready;

    // Load sequencing: next state, write address, remaining count, error flag.
    always_comb begin : next_state
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        err_d   = err_q;
        if (pop_c) begin
            addr_d = addr_q + ADDR_W'(4);
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (prog_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        addr_d  = base_addr & ~ADDR_W'(3);
                        rem_d   = prog_len;
                    end
                end
            end
            ST_RUN: begin
                if (accept_c && !legal_c) begin
                    err_d = 1'b1;
                end
                if (push_c) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointer and occupancy update.
    always_comb begin : fifo_next
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk) begin : state_reg
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage is cleared on reset so the idle head word reads as zero.
    always_ff @(posedge clk) begin : fifo_mem
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_c) begin
            mem_q[wr_ptr_q] <= enc_word_c;
        end
    end

    assign wr_valid    = !fifo_empty_c;
    assign wr_addr     = addr_q;
    assign wr_data     = mem_q[rd_ptr_q];
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign err_illegal = err_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: queue-based reference model of
// the encoded word stream plus directed and randomized loads.
`timescale 1ns/1ps
module tb_mips_instr_encoder;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  prog_len;
    logic              op_valid;
    logic              op_ready;
    logic [4:0]        op_sel;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic              wr_valid;
    logic              wr_ready = 1'b0;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;
    logic              err_illegal;

    always #5 clk = ~clk;

    mips_instr_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .prog_len(prog_len), .op_valid(op_valid), .op_ready(op_ready),
        .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .err_illegal(err_illegal)
    );

    int total = 0;
    int bad   = 0;

    bit [5:0] funct_tab [9] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a};
    bit [5:0] opc_tab   [9] = '{6'h04, 6'h05, 6'h23, 6'h2b, 6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Returns {legal, word} from the instruction-format rules.
    function automatic logic [32:0] encode(input logic [4:0] s, input logic [4:0] r_s,
                                           input logic [4:0] r_t, input logic [4:0] r_d,
                                           input logic [15:0] im);
        int sel = int'(s);
        logic [31:0] w;
        if (sel < 9) begin
            w = (32'(r_s) << 21) | (32'(r_t) << 16) | (32'(r_d) << 11) | 32'(funct_tab[sel]);
        end else if (sel < 18) begin
            w = (32'(opc_tab[sel-9]) << 26) | (32'(r_s) << 21) | (32'(r_t) << 16) | 32'(im);
        end else begin
            return {1'b0, 32'h0};
        end
        return {1'b1, w};
    endfunction

    // Reference model state.
    logic [31:0] exp_q [$];
    logic [31:0] m_addr = '0;
    int          m_rem = 0;
    bit          m_loading = 0, m_active = 0, m_err = 0, m_done_due = 0;
    bit          prev_done = 0, chk_en = 0;
    int          acc_dut = 0, done_cnt = 0;
    logic [63:0] wlog [$];
    bit          mx_rdy, mx_pop;
    logic [32:0] mx_enc;
    int          rdy_mode = 1;

    // Compare process: check outputs against the model, then advance the model
    // by what will happen at the coming rising edge.
    always @(negedge clk) begin
        mx_rdy = m_loading && (m_rem != 0) && (exp_q.size() < int'(DEPTH));
        if (chk_en) begin
            chk("wr_valid", 32'(wr_valid), 32'(exp_q.size() != 0));
            chk("op_ready", 32'(op_ready), 32'(mx_rdy));
            chk("err_illegal", 32'(err_illegal), 32'(m_err));
            chk("busy", 32'(busy), 32'(m_active));
            if (exp_q.size() != 0) begin
                chk("wr_data", wr_data, exp_q[0]);
                chk("wr_addr", wr_addr, m_addr);
            end
            if (m_done_due) chk("done_len0", 32'(done), 32'd1);
            else if (m_loading || exp_q.size() != 0 || prev_done) chk("done_quiet", 32'(done), 32'd0);
        end
        if (!rst_n) begin
            exp_q.delete();
            m_addr = '0; m_rem = 0; m_loading = 0; m_active = 0; m_err = 0; m_done_due = 0;
        end else begin
            if (wr_valid && wr_ready) wlog.push_back({wr_addr, wr_data});
            if (op_valid && op_ready) acc_dut++;
            m_done_due = 0;
            mx_pop = (exp_q.size() != 0) && wr_ready;
            if (mx_pop) begin
                void'(exp_q.pop_front());
                m_addr = m_addr + 32'd4;
            end
            if (op_valid && mx_rdy) begin
                mx_enc = encode(op_sel, rs, rt, rd, imm);
                if (mx_enc[32]) begin
                    exp_q.push_back(mx_enc[31:0]);
                    m_rem--;
                    if (m_rem == 0) m_loading = 0;
                end else begin
                    m_err = 1;
                end
            end
            if (start && !m_active) begin
                m_active = 1;
                m_err = 0;
                if (prog_len == '0) begin
                    m_done_due = 1;
                end else begin
                    m_loading = 1;
                    m_rem = int'(prog_len);
                    m_addr = base_addr & ~32'd3;
                end
            end
            if (done) begin
                m_active = 0;
                done_cnt++;
            end
        end
        prev_done = done;
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       wr_ready = 1'b0;
            1:       wr_ready = 1'b1;
            default: wr_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [31:0] b, input int len);
        base_addr = b;
        prog_len  = CNT_W'(len);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_op(input logic [4:0] s, input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] c, input logic [15:0] i);
        bit got = 0;
        op_sel = s; rs = a; rt = b; rd = c; imm = i;
        op_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (op_ready) begin
                got = 1;
                break;
            end
        end
        tick();
        op_valid = 1'b0;
        chk("op_accepted", 32'(got), 32'd1);
    endtask

    task automatic wait_done;
        bit got = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        tick();
        chk("done_seen", 32'(got), 32'd1);
    endtask

    task automatic rand_load(input int len, input logic [31:0] b);
        int sent = 0;
        logic [4:0] s;
        wlog.delete();
        start_load(b, len);
        while (sent < len) begin
            repeat ($urandom_range(0, 2)) tick();
            s = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
            send_op(s, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
            if (s < 5'd18) sent++;
            if (sent == 1 && len > 1 && $urandom_range(0, 1) == 1) begin
                base_addr = $urandom();
                prog_len  = CNT_W'($urandom_range(0, 20));
                start     = 1'b1;
                tick();
                start     = 1'b0;
            end
        end
        wait_done();
        chk("rand_nwr", 32'(wlog.size()), 32'(len));
    endtask

    logic [63:0] e;
    int          a0, d0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; prog_len = '0; op_valid = 1'b0;
        op_sel = '0; rs = '0; rt = '0; rd = '0; imm = '0; rdy_mode = 1;
        tick();
        chk_en = 1;
        tick();
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_op_ready", 32'(op_ready), 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_illegal), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single add.
        wlog.delete(); d0 = done_cnt;
        start_load(32'h100, 1);
        send_op(5'd0, 5'd1, 5'd2, 5'd3, 16'h5555);
        wait_done();
        chk("t1_nwr", 32'(wlog.size()), 32'd1);
        e = wlog[0];
        chk("t1_addr", e[63:32], 32'h100);
        chk("t1_data", e[31:0], 32'h00221820);
        chk("t1_busy_after", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Four I-type words.
        wlog.delete();
        start_load(32'h100, 4);
        send_op(5'd11, 5'd29, 5'd8, 5'd0, 16'h0004);
        send_op(5'd12, 5'd0, 5'd9, 5'd0, 16'h0008);
        send_op(5'd9, 5'd1, 5'd2, 5'd0, 16'hFFFF);
        send_op(5'd17, 5'd5, 5'd5, 5'd0, 16'h00FF);
        wait_done();
        chk("t2_nwr", 32'(wlog.size()), 32'd4);
        e = wlog[0]; chk("t2_w0", e[31:0], 32'h8FA80004); chk("t2_a0", e[63:32], 32'h100);
        e = wlog[1]; chk("t2_w1", e[31:0], 32'hAC090008); chk("t2_a1", e[63:32], 32'h104);
        e = wlog[2]; chk("t2_w2", e[31:0], 32'h1022FFFF); chk("t2_a2", e[63:32], 32'h108);
        e = wlog[3]; chk("t2_w3", e[31:0], 32'h38A500FF); chk("t2_a3", e[63:32], 32'h10C);

        // Backpressure: FIFO fills to DEPTH and holds.
        wlog.delete(); rdy_mode = 0; tick();
        start_load(32'h400, 8);
        a0 = acc_dut;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send_op(5'($urandom_range(0, 17)), 5'($urandom), 5'($urandom),
                            5'($urandom), 16'($urandom));
            end
            begin
                repeat (20) @(negedge clk);
                chk("t3_accepted", 32'(acc_dut - a0), 32'(DEPTH));
                chk("t3_ready_low", 32'(op_ready), 32'd0);
                chk("t3_valid_held", 32'(wr_valid), 32'd1);
                rdy_mode = 1;
            end
        join
        wait_done();
        chk("t3_nwr", 32'(wlog.size()), 32'd8);
        for (int i = 0; i < wlog.size(); i++) begin
            e = wlog[i];
            chk("t3_addr", e[63:32], 32'h400 + 32'(4 * i));
        end

        // Illegal op dropped, error sticky.
        wlog.delete();
        start_load(32'h200, 2);
        send_op(5'd20, 5'd1, 5'd1, 5'd1, 16'h1111);
        send_op(5'd16, 5'd3, 5'd4, 5'd7, 16'h1234);
        send_op(5'd2, 5'd1, 5'd2, 5'd3, 16'h0000);
        wait_done();
        chk("t4_err", 32'(err_illegal), 32'd1);
        chk("t4_nwr", 32'(wlog.size()), 32'd2);
        e = wlog[0]; chk("t4_w0", e[31:0], 32'h34641234); chk("t4_a0", e[63:32], 32'h200);
        e = wlog[1]; chk("t4_w1", e[31:0], 32'h00221822); chk("t4_a1", e[63:32], 32'h204);

        // Address wrap; start also clears the sticky error.
        wlog.delete();
        start_load(32'hFFFF_FFFC, 2);
        chk("t5_err_cleared", 32'(err_illegal), 32'd0);
        send_op(5'd14, 5'd0, 5'd1, 5'd0, 16'h0007);
        send_op(5'd1, 5'd4, 5'd5, 5'd6, 16'h0000);
        wait_done();
        chk("t5_nwr", 32'(wlog.size()), 32'd2);
        e = wlog[0]; chk("t5_a0", e[63:32], 32'hFFFF_FFFC); chk("t5_w0", e[31:0], 32'h24010007);
        e = wlog[1]; chk("t5_a1", e[63:32], 32'h0000_0000);

        // Zero-length load.
        wlog.delete();
        start_load(32'h300, 0);
        chk("t6_done", 32'(done), 32'd1);
        tick();
        chk("t6_done_low", 32'(done), 32'd0);
        chk("t6_busy_low", 32'(busy), 32'd0);
        chk("t6_nwr", 32'(wlog.size()), 32'd0);

        // Reset in the middle of a load.
        rdy_mode = 0; tick();
        start_load(32'h500, 8);
        send_op(5'd25, 5'd0, 5'd0, 5'd0, 16'h0);
        for (int i = 0; i < 3; i++) send_op(5'd4, 5'(i), 5'(i + 1), 5'(i + 2), 16'h0);
        rst_n = 1'b0;
        tick();
        chk("mr_wr_valid", 32'(wr_valid), 32'd0);
        chk("mr_op_ready", 32'(op_ready), 32'd0);
        chk("mr_wr_addr", wr_addr, 32'd0);
        chk("mr_wr_data", wr_data, 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        chk("mr_err", 32'(err_illegal), 32'd0);
        rst_n = 1'b1; rdy_mode = 1;
        tick();
        wlog.delete();
        start_load(32'h600, 3);
        for (int i = 0; i < 3; i++) send_op(5'd13, 5'd2, 5'd3, 5'd0, 16'(i));
        wait_done();
        chk("mr_nwr", 32'(wlog.size()), 32'd3);
        e = wlog[0]; chk("mr_a0", e[63:32], 32'h600); chk("mr_w0", e[31:0], 32'h20430000);

        // Randomized loads with random backpressure.
        rdy_mode = 2;
        for (int n = 0; n < 14; n++) begin
            rand_load($urandom_range(0, 10),
                      ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                  : 32'($urandom()));
        end

        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Inverse of the control/decode path: turns symbolic operation requests (operation select plus register and immediate fields) into 32-bit MIPS instruction words.
- Buffers the encoded words in a small FIFO and streams them to instruction memory at sequential word addresses.
- Used by the program loader and the self-test sequencer to fill IMEM before the pipeline is released from reset.
- Supports exactly the instruction set the control unit decodes.

Parameters:
- ADDR_W, 32, width of the IMEM byte address.
- CNT_W, 16, width of the program-length counter.
- DEPTH, 4, encoded-word FIFO depth; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  begin a load; sampled only in IDLE.
- base_addr  in  ADDR_W  first IMEM byte address; low 2 bits ignored and treated as 0.
- prog_len  in  CNT_W  number of legal instructions to write.
- op_valid  in  1  request valid.
- op_ready  out  1  request accepted when op_valid && op_ready.
- op_sel  in  5  operation select, encoding listed in Behaviour.
- rs, rt, rd  in  5 each  register fields.
- imm  in  16  immediate / branch offset, passed through unchanged.
- wr_valid  out  1  IMEM write request.
- wr_ready  in  1  IMEM accepts the write when wr_valid && wr_ready.
- wr_addr  out  ADDR_W  byte address.
- wr_data  out  32  encoded instruction.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a load completes.
- err_illegal  out  1  sticky: an illegal op_sel was accepted.

Behaviour:
- op_sel encoding:
  - 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 xor, 7 nor, 8 slt
  - 9 beq, 10 bne, 11 lw, 12 sw, 13 addi, 14 addiu, 15 andi, 16 ori, 17 xori
  - 18..31 illegal
- R-type (0..8): word = {6'h00, rs, rt, rd, 5'h00, funct}. imm ignored. funct values: 20,21,22,23,24,25,26,27,2a (hex), in op_sel order.
- I-type (9..17): word = {opcode, rs, rt, imm}. rd ignored. opcode values: 04,05,23,2b,08,09,0c,0d,0e (hex), in op_sel order.
- States:
  - IDLE: start moves to RUN. On entry to RUN, latch base_addr into addr_q and load remaining = prog_len. If prog_len == 0, go IDLE→DONE instead and never enter RUN.
  - RUN: op_ready = !fifo_full && (remaining != 0). Each accepted legal op is pushed to the FIFO and decrements remaining. When remaining reaches 0, go to DRAIN.
  - DRAIN: op_ready = 0. When the FIFO is empty, go to DONE.
  - DONE: done = 1 for exactly one cycle, then IDLE.
- Illegal op:
  - Accepted (handshake completes), dropped, not counted, no FIFO push.
  - err_illegal set; cleared only by reset or by start in IDLE.
- FIFO and write port:
  - Show-ahead FIFO; wr_valid = !fifo_empty; wr_data = FIFO head.
  - Latency: op accepted at edge N → wr_valid high from cycle N+1. No combinational bypass.
  - On each wr_valid && wr_ready: pop the head, and addr_q += 4. Wraps modulo 2^ADDR_W with no error.
  - wr_addr = addr_q.
  - Push and pop in the same cycle are allowed. When full, op_ready is already 0 that cycle; no push-on-pop.
  - wr_valid/wr_addr/wr_data stay stable while wr_valid && !wr_ready.
- start while not IDLE is ignored.
- Reset (also mid-load): state IDLE, FIFO emptied, addr_q = 0, remaining = 0, op_ready = 0, wr_valid = 0, wr_addr = 0, wr_data = 0, busy = 0, done = 0, err_illegal = 0. Pending words are discarded.

Test Plan:
- start, base 0x0000_0100, len 1; add rs=1 rt=2 rd=3 → one write: addr 0x100, data 0x00221820; done pulses once; busy falls the cycle after done.
- len 4, wr_ready=1; lw rt=8 rs=29 imm=4; sw rt=9 rs=0 imm=8; beq rs=1 rt=2 imm=0xFFFF; xori rs=5 rt=5 imm=0x00FF → writes in order:
  - 0x8FA80004 @0x100
  - 0xAC090008 @0x104
  - 0x1022FFFF @0x108
  - 0x38A500FF @0x10C
- wr_ready=0, len 8, op_valid held high → exactly DEPTH (4) ops accepted, then op_ready=0. Outputs hold stable. After wr_ready is raised, all 8 are written in order with no loss or duplication.
- len 2 with sequence op_sel=20, then ori, then sub → illegal op handshaken; err_illegal=1; exactly 2 writes (ori, sub) at consecutive addresses.
- base 0xFFFF_FFFC, len 2 → writes at 0xFFFFFFFC then 0x00000000.
- len 0 → done the cycle after start with no writes. Separately, assert rst_n=0 mid-load → all outputs at reset values next edge; the next load starts cleanly.
